// File: rtl/csa_resolve.sv
// Chunk-serial carry-propagate resolver: out_sum = pv_s + pv_c, CHUNK bits per cycle, low chunk first.
// Optional macro CSA_RESOLVE_COUT_EN adds the out_cout port (carry out of the top chunk).

module csa_resolve_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

module csa_resolve #(
  parameter int MAX   = 16,
  parameter int CHUNK = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [MAX-1:0] pv_s,
  input  logic [MAX-1:0] pv_c,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [MAX-1:0] out_sum
`ifdef CSA_RESOLVE_COUT_EN
  ,
  output logic           out_cout
`endif
);
  localparam int NCHUNK = MAX / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  if (MAX % CHUNK != 0) begin : g_bad_chunk
    $error("csa_resolve: MAX must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [MAX-1:0]   s_q, c_q, sum_q;
  logic [31:0]      base;
  logic [CHUNK-1:0] s_chunk, c_chunk, sum_chunk;
  logic             cout_chunk;

  assign base    = 32'(idx_q) * 32'(CHUNK);
  assign s_chunk = s_q[base +: CHUNK];
  assign c_chunk = c_q[base +: CHUNK];

  csa_resolve_chunk #(.W(CHUNK)) u_chunk (
    .a    (s_chunk),
    .b    (c_chunk),
    .cin  (carry_q),
    .sum  (sum_chunk),
    .cout (cout_chunk)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)        state_d = ADD;
      ADD:     if (idx_q == LAST)   state_d = DONE;
      DONE:    if (out_ready)       state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // handshake outputs decode from registered state only
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_q     <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          s_q     <= pv_s;
          c_q     <= pv_c;
          carry_q <= 1'b0;
          idx_q   <= '0;
        end
        ADD: begin
          sum_q[base +: CHUNK] <= sum_chunk;
          carry_q              <= cout_chunk;
          idx_q                <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_sum = sum_q;

`ifdef CSA_RESOLVE_COUT_EN
  logic cout_q;
  // the top chunk's carry is captured alongside its sum bits and then held through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              cout_q <= 1'b0;
    else if (state_q == ADD && idx_q == LAST) cout_q <= cout_chunk;
  end
  assign out_cout = cout_q;
`endif

endmodule

// File: tb/tb_csa_resolve.sv
// Directed bench for csa_resolve: a CHUNK=4 instance and a single-chunk (CHUNK=MAX) instance.
module tb_csa_resolve;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] pv_s = '0, pv_c = '0;
  logic        in_ready, out_valid;
  logic [15:0] out_sum;
  logic        in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [15:0] pv_s1 = '0, pv_c1 = '0;
  logic        in_ready1, out_valid1;
  logic [15:0] out_sum1;
`ifdef CSA_RESOLVE_COUT_EN
  logic        out_cout, out_cout1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csa_resolve #(.MAX(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pv_s(pv_s), .pv_c(pv_c), .out_valid(out_valid), .out_ready(out_ready),
`ifdef CSA_RESOLVE_COUT_EN
    .out_cout(out_cout),
`endif
    .out_sum(out_sum)
  );

  csa_resolve #(.MAX(16), .CHUNK(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .pv_s(pv_s1), .pv_c(pv_c1), .out_valid(out_valid1), .out_ready(out_ready1),
`ifdef CSA_RESOLVE_COUT_EN
    .out_cout(out_cout1),
`endif
    .out_sum(out_sum1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // accept one pair on the CHUNK=4 instance and return cycles until out_valid
  task automatic run4(input logic [15:0] s, input logic [15:0] c, output int n);
    pv_s = s; pv_c = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 20);
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  int n;
  int acc_cyc [2];
  logic [15:0] res [2];
  int nacc, nres;
  logic acc, fire;

  initial begin
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // 1: basic carry chain across chunks, latency
    run4(16'h00FF, 16'h0001, n);
    chk("t1_latency", n, 4);
    chk("t1_sum", 32'(out_sum), 32'h0100);
    chk("t1_in_ready_done", 32'(in_ready), 0);
`ifdef CSA_RESOLVE_COUT_EN
    chk("t1_cout", 32'(out_cout), 0);
`endif
    handoff();
    chk("t1_valid_drop", 32'(out_valid), 0);
    chk("t1_ready_back", 32'(in_ready), 1);

    // 2: wrap-around
    run4(16'hFFFF, 16'h0001, n);
    chk("t2_latency", n, 4);
    chk("t2_sum", 32'(out_sum), 32'h0000);
`ifdef CSA_RESOLVE_COUT_EN
    chk("t2_cout", 32'(out_cout), 1);
`endif
    handoff();

    // 3: backpressure in DONE with a pending second request
    run4(16'h0F0F, 16'h0101, n);
    chk("t3_sum", 32'(out_sum), 32'h1010);
    pv_s = 16'h0001; pv_c = 16'h0001; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_sum", 32'(out_sum), 32'h1010);
      chk("t3_hold_in_ready", 32'(in_ready), 0);
      chk("t3_hold_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_idle_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("t3_second_accepted", 32'(in_ready), 0);
    n = 0;
    do begin tick(); n++; end while (!out_valid && n < 20);
    chk("t3_second_latency", n, 4);
    chk("t3_second_sum", 32'(out_sum), 32'h0002);
    handoff();

    // 4: reset in the middle of ADD (idx=2)
    pv_s = 16'hAAAA; pv_c = 16'h5555; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #2;
    chk("t4_rst_valid", 32'(out_valid), 0);
    chk("t4_rst_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    #1;
    chk("t4_rel_ready", 32'(in_ready), 1);
    chk("t4_rel_sum", 32'(out_sum), 0);
    tick();
    chk("t4_stays_idle", 32'(out_valid), 0);
    run4(16'h1234, 16'h1111, n);
    chk("t4_sum", 32'(out_sum), 32'h2345);
    handoff();

    // 5: streaming with in_valid and out_ready held high
    pv_s = 16'h0001; pv_c = 16'h0002; in_valid = 1'b1; out_ready = 1'b1;
    acc_cyc[0] = -1; acc_cyc[1] = -1; res[0] = 'x; res[1] = 'x;
    nacc = 0; nres = 0;
    for (int c = 0; c < 40 && nres < 2; c++) begin
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (fire) begin res[nres] = out_sum; nres++; end
      tick();
      if (acc) begin
        acc_cyc[nacc] = c;
        nacc++;
        if (nacc == 1) begin pv_s = 16'hA5A0; pv_c = 16'h0005; end
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    chk("t5_nres", nres, 2);
    chk("t5_acc0", acc_cyc[0], 0);
    chk("t5_acc1", acc_cyc[1], 6);
    chk("t5_res0", 32'(res[0]), 32'h0003);
    chk("t5_res1", 32'(res[1]), 32'hA5A5);

    // 6: single-chunk instance
    chk("t6_idle_ready", 32'(in_ready1), 1);
    pv_s1 = 16'h8000; pv_c1 = 16'h8000; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!out_valid1 && n < 20);
    chk("t6_latency", n, 1);
    chk("t6_sum", 32'(out_sum1), 32'h0000);
`ifdef CSA_RESOLVE_COUT_EN
    chk("t6_cout", 32'(out_cout1), 1);
`endif
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    chk("t6_ready_back", 32'(in_ready1), 1);
    pv_s1 = 16'h0FFF; pv_c1 = 16'h0001; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    tick();
    chk("t6b_valid", 32'(out_valid1), 1);
    chk("t6b_sum", 32'(out_sum1), 32'h1000);
`ifdef CSA_RESOLVE_COUT_EN
    chk("t6b_cout", 32'(out_cout1), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
